// File: rtl/key_debounce_pulse.sv
// Push-button front end: per-key two-flop synchroniser, debounce FSM, and
// registered level plus single-cycle press/release strobes with optional auto-repeat.
module key_debounce_pulse #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 0,
  parameter int CNT_W           = 20
) (
  input  logic         clk,
  input  logic         clear,
  input  logic [N-1:0] key_n,
  output logic [N-1:0] level,
  output logic [N-1:0] press_pulse,
  output logic [N-1:0] release_pulse
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam bit               REPEAT_EN = (REPEAT_CYCLES != 0);

  logic [N-1:0] s1;
  logic [N-1:0] s2;

  // Released (1) is the safe reset value so a held key is seen as a fresh press.
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    if (!clear) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= key_n;
      s2 <= s1;
    end
  end

  for (genvar ch = 0; ch < N; ch++) begin : g_ch
    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             press_nx;
    logic             release_nx;
    logic             level_q;
    logic             press_q;
    logic             release_q;

    always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch
      // is inferred.
      state_nx   = state;
      cnt_nx     = cnt;
      press_nx   = 1'b0;
      release_nx = 1'b0;
      case (state)
        IDLE: begin
          if (!s2[ch]) begin
            state_nx = WAIT_PRESS;
            cnt_nx   = '0;
          end
        end
        WAIT_PRESS: begin
          if (s2[ch]) begin
            state_nx = IDLE;
          end else if (cnt == DEB_LAST) begin
            state_nx = PRESSED;
            press_nx = 1'b1;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (s2[ch]) begin
            state_nx = WAIT_RELEASE;
            cnt_nx   = '0;
          end else if (REPEAT_EN) begin
            if (cnt == REP_LAST) begin
              press_nx = 1'b1;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
        end
        WAIT_RELEASE: begin
          // A low sample here is release bounce; the repeat interval restarts.
          if (!s2[ch]) begin
            state_nx = PRESSED;
            cnt_nx   = '0;
          end else if (cnt == DEB_LAST) begin
            state_nx   = IDLE;
            release_nx = 1'b1;
            cnt_nx     = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end

    // Outputs are registered from the next state so a strobe lines up with
    // the first cycle of the new level.
    always_ff @(posedge clk) begin
      if (!clear) begin
        state     <= IDLE;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_nx;
        cnt       <= cnt_nx;
        level_q   <= (state_nx == PRESSED) || (state_nx == WAIT_RELEASE);
        press_q   <= press_nx;
        release_q <= release_nx;
      end
    end

    assign level[ch]         = level_q;
    assign press_pulse[ch]   = press_q;
    assign release_pulse[ch] = release_q;
  end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Scoreboard bench: expected strobe events (edge number, strobes, level) are
// queued when keys are driven and matched whenever a DUT strobes.
module tb_key_debounce_pulse;

  localparam int D = 4;
  localparam int R = 5;
  localparam int LAT = D + 3;

  logic       clk = 1'b0;
  logic       clear;
  logic [3:0] key_n0, key_n1;
  logic [3:0] level0, pp0, rp0;
  logic [3:0] level1, pp1, rp1;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lvl;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  key_debounce_pulse #(.N(4), .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(0), .CNT_W(4)) dut0 (
    .clk(clk), .clear(clear), .key_n(key_n0),
    .level(level0), .press_pulse(pp0), .release_pulse(rp0)
  );

  key_debounce_pulse #(.N(4), .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R), .CNT_W(4)) dut1 (
    .clk(clk), .clear(clear), .key_n(key_n1),
    .level(level1), .press_pulse(pp1), .release_pulse(rp1)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push0(input int c, input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.lvl = l;
    q0.push_back(e);
  endtask

  task automatic push1(input int c, input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.lvl = l;
    q1.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if ((pp0 | rp0) != 4'b0) begin
      if (q0.size() == 0) begin
        check("dut0_unexpected_strobe", {24'b0, pp0, rp0}, 32'b0);
      end else begin
        ev_t e;
        e = q0.pop_front();
        check("dut0_edge", cyc, e.cyc);
        check("dut0_press", pp0, e.press);
        check("dut0_release", rp0, e.rel);
        check("dut0_level", level0, e.lvl);
      end
    end
  end

  always @(negedge clk) begin
    if ((pp1 | rp1) != 4'b0) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_strobe", {24'b0, pp1, rp1}, 32'b0);
      end else begin
        ev_t e;
        e = q1.pop_front();
        check("dut1_edge", cyc, e.cyc);
        check("dut1_press", pp1, e.press);
        check("dut1_release", rp1, e.rel);
        check("dut1_level", level1, e.lvl);
      end
    end
  end

  initial begin
    clear  = 1'b0;
    key_n0 = 4'b1111;
    key_n1 = 4'b1111;
    tick(3);
    check("reset_level0", level0, 4'b0);
    check("reset_press0", pp0, 4'b0);
    check("reset_release0", rp0, 4'b0);
    check("reset_level1", level1, 4'b0);
    clear = 1'b1;
    tick(2);

    // Clean press and release on channel 0; other channels stay idle.
    key_n0[0] = 1'b0;
    push0(cyc + LAT, 4'b0001, 4'b0000, 4'b0001);
    tick(12);
    check("ch0_held_level", level0, 4'b0001);
    key_n0[0] = 1'b1;
    push0(cyc + LAT, 4'b0000, 4'b0001, 4'b0000);
    tick(12);
    check("ch0_released_level", level0, 4'b0000);
    check("ch0_pending", 32'(q0.size()), 32'd0);

    // Press bounce on channel 1 is rejected, then a held press is accepted once.
    key_n0[1] = 1'b0; tick(3);
    key_n0[1] = 1'b1; tick(1);
    key_n0[1] = 1'b0; tick(2);
    key_n0[1] = 1'b1; tick(10);
    check("ch1_bounce_level", level0, 4'b0000);
    key_n0[1] = 1'b0;
    push0(cyc + LAT, 4'b0010, 4'b0000, 4'b0010);
    tick(10);
    check("ch1_held_level", level0, 4'b0010);
    key_n0[1] = 1'b1;
    push0(cyc + LAT, 4'b0000, 4'b0010, 4'b0000);
    tick(12);
    check("ch1_pending", 32'(q0.size()), 32'd0);

    // Release bounce on channel 2 keeps the level high until the high is stable.
    key_n0[2] = 1'b0;
    push0(cyc + LAT, 4'b0100, 4'b0000, 4'b0100);
    tick(12);
    key_n0[2] = 1'b1; tick(2);
    key_n0[2] = 1'b0; tick(1);
    key_n0[2] = 1'b1;
    push0(cyc + LAT, 4'b0000, 4'b0100, 4'b0000);
    tick(4);
    check("ch2_bounce_level", level0, 4'b0100);
    tick(8);
    check("ch2_released_level", level0, 4'b0000);
    check("ch2_pending", 32'(q0.size()), 32'd0);

    // All channels pressed together strobe together for one cycle.
    key_n0 = 4'b0000;
    push0(cyc + LAT, 4'b1111, 4'b0000, 4'b1111);
    tick(LAT + 1);
    check("all_press_width", pp0, 4'b0000);
    tick(4);
    key_n0 = 4'b1111;
    push0(cyc + LAT, 4'b0000, 4'b1111, 4'b0000);
    tick(12);
    check("all_pending", 32'(q0.size()), 32'd0);

    // Auto-repeat on the second instance: initial strobe plus one every R cycles.
    begin
      int e;
      e = cyc;
      key_n1[3] = 1'b0;
      for (int i = 0; i < 5; i++) push1(e + LAT + i * R, 4'b1000, 4'b0000, 4'b1000);
      tick(28);
      key_n1[3] = 1'b1;
      push1(cyc + LAT, 4'b0000, 4'b1000, 4'b0000);
      tick(12);
      check("repeat_pending", 32'(q1.size()), 32'd0);
      check("repeat_level", level1, 4'b0000);
    end

    // Reset mid-operation: ch1 pressed, ch0 about to be accepted (strobe dropped).
    key_n0[1] = 1'b0;
    push0(cyc + LAT, 4'b0010, 4'b0000, 4'b0010);
    tick(12);
    key_n0[0] = 1'b0;
    tick(LAT - 1);
    clear = 1'b0;
    tick(1);
    check("midreset_level", level0, 4'b0000);
    check("midreset_press", pp0, 4'b0000);
    check("midreset_release", rp0, 4'b0000);
    clear = 1'b1;
    push0(cyc + LAT, 4'b0011, 4'b0000, 4'b0011);
    tick(12);
    key_n0[1:0] = 2'b11;
    push0(cyc + LAT, 4'b0000, 4'b0011, 4'b0000);
    tick(12);
    check("final_pending0", 32'(q0.size()), 32'd0);
    check("final_pending1", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce_pulse.md
Name: key_debounce_pulse

Overview:
Front-end conditioner between the raw DE2 push-buttons (KEY, active-low, bouncy, asynchronous to CLOCK_50) and the counters and registers that consume them. Each key is:
- synchronised into the clock domain,
- debounced with a per-key timing FSM,
- converted into a clean level plus single-cycle press/release strobes.

Strobes drive counter enables/clocks (e.g. the mod-6 sync-load counter) without multi-counting on contact bounce. Optional auto-repeat re-emits press strobes while a key is held.

Parameters:
N, 4, number of independent key channels
DEBOUNCE_CYCLES, 500000, stable cycles required to accept a change (10 ms at 50 MHz); legal range >= 2
REPEAT_CYCLES, 0, hold time between auto-repeat press strobes; 0 disables auto-repeat
CNT_W, 20, width of each debounce/repeat counter; must hold max(DEBOUNCE_CYCLES, REPEAT_CYCLES)

Ports:
clk  input  1  system clock (CLOCK_50); all logic on rising edge
clear  input  1  synchronous active-low reset; sampled on rising clk
key_n  input  N  raw keys, active-low (0 = pressed), asynchronous
level  output  N  debounced state, active-high (1 = pressed)
press_pulse  output  N  one-cycle strobe on accepted press (and on each auto-repeat)
release_pulse  output  N  one-cycle strobe on accepted release

Behaviour:
- Channels are fully independent; simultaneous activity on several keys produces independent results.

Synchroniser:
- Two-flop chain per key (s1, s2).
- Reset value 1 (released).
- FSM sees only s2.

Per-key FSM states: IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE.
- IDLE: s2==0 -> WAIT_PRESS, cnt<=0. Otherwise stay.
- WAIT_PRESS:
  - s2==1 -> IDLE (bounce rejected, no strobe).
  - s2==0 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED; press_pulse=1 next cycle; cnt<=0.
  - Otherwise cnt<=cnt+1.
- PRESSED:
  - s2==1 -> WAIT_RELEASE, cnt<=0.
  - Else, if REPEAT_CYCLES!=0: cnt increments; at cnt==REPEAT_CYCLES-1 press_pulse=1 next cycle, cnt<=0.
- WAIT_RELEASE:
  - s2==0 -> PRESSED (bounce rejected; repeat count restarts at 0).
  - s2==1 and cnt==DEBOUNCE_CYCLES-1 -> IDLE; release_pulse=1 next cycle.
  - Otherwise cnt<=cnt+1.

Outputs:
- All outputs are registered.
- level=1 in PRESSED and WAIT_RELEASE, 0 in IDLE and WAIT_PRESS.
- A strobe is exactly one cycle wide, coincident with the first cycle of the new level.
- press_pulse and release_pulse are never high together on one channel.

Latency:
- A raw change stable before rising edge k is accepted at edge k+DEBOUNCE_CYCLES+2.
- Total is DEBOUNCE_CYCLES+3 edges, including edge k.

Counter:
- cnt never exceeds max(DEBOUNCE_CYCLES, REPEAT_CYCLES)-1.
- No wrap is possible.

Reset (clear==0 at a rising edge):
- All channels -> IDLE, cnt=0, s1=s2=1.
- level, press_pulse and release_pulse = 0 on the following cycle, regardless of state.
- A strobe in flight is dropped.
- A key held through deassertion of reset is treated as a fresh press: full debounce, then press_pulse.

Test Plan:
- DEBOUNCE_CYCLES=4, REPEAT_CYCLES=0: key_n[0] 1->0 held -> level[0]=1 and press_pulse[0]=1 for exactly one cycle, 7 edges after the change. Other channels stay 0.
- Bounce: key_n[1] low 3 cycles, high 1, low 2, high -> no press_pulse, level[1] stays 0. Then low held 10 cycles -> exactly one press_pulse.
- Release with bounce: from PRESSED, key_n[2] high 2 cycles, low 1, then high held -> level[2] stays 1 until 4 consecutive stable-high FSM cycles. Then exactly one release_pulse and level 0.
- Auto-repeat, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=5: hold key_n[3] low 30 cycles -> initial press_pulse, then a press_pulse every 5 cycles (5 strobes total in window). One release_pulse after release.
- Reset mid-operation: clear=0 while key_n[0] is in WAIT_PRESS and key_n[1] in PRESSED -> all outputs 0 next cycle. After clear=1 with key_n[1] still held -> press_pulse[1] 7 edges later.
- Simultaneous: key_n[3:0]=4'b0000 at the same edge -> press_pulse=4'b1111 in the same cycle, each one cycle wide.
